// File: rtl/stupidrv_pkg.sv
// Shared types and constants for the stupidrv memory sequencer.
package stupidrv_pkg;

   typedef enum logic [1:0] {
      S_COMMIT,
      S_DATA,
      S_FETCH
   } memctl_state_t;

   localparam logic [31:0] MEMCTL_WORD_MASK = 32'hffff_fffc;

endpackage

// File: rtl/stupidrv_memctl_fetchtag.sv
// One-entry tag of the last completed fetch word, so a repeated fetch of an
// unchanged word can skip its bus cycle. Used only with STUPIDRV_MEMCTL_FETCHSKIP_EN.
module stupidrv_memctl_fetchtag
   import stupidrv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] lookup_addr,
   output logic        hit,
   input  logic        fill_en,
   input  logic [31:0] fill_addr,
   input  logic        inv_en,
   input  logic [31:0] inv_addr
);

   logic [31:0] tag_q;
   logic        valid_q;
   logic        inv_match;

   assign inv_match = inv_en && ((inv_addr & MEMCTL_WORD_MASK) == tag_q);

   // A write completing this cycle already counts as an invalidation, so a
   // store to the fetched word never lets the following fetch be skipped.
   assign hit = valid_q && !inv_match &&
                ((lookup_addr & MEMCTL_WORD_MASK) == tag_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         tag_q   <= '0;
         valid_q <= 1'b0;
      end else if (fill_en) begin
         tag_q   <= fill_addr & MEMCTL_WORD_MASK;
         valid_q <= 1'b1;
      end else if (inv_match) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/stupidrv_memctl.sv
// Serialises the stupidrv core's instruction and data ports onto one
// valid/ready memory bus. Optional fetch skip: STUPIDRV_MEMCTL_FETCHSKIP_EN.
module stupidrv_memctl
   import stupidrv_pkg::*;
#(
   parameter logic [31:0] RESET_INSN = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        stall,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_data,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_wstrb,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   memctl_state_t state, state_next;

   logic [31:0] req_iaddr;
   logic [31:0] req_daddr;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic        fetch_hit;

`ifdef STUPIDRV_MEMCTL_FETCHSKIP_EN
   logic [31:0] lookup_addr;

   // In COMMIT the fetch address is still on the core port; later it is captured.
   assign lookup_addr = (state == S_COMMIT) ? imem_addr : req_iaddr;

   stupidrv_memctl_fetchtag u_fetchtag (
      .clock       (clock),
      .reset       (reset),
      .lookup_addr (lookup_addr),
      .hit         (fetch_hit),
      .fill_en     ((state == S_FETCH) && mem_ready),
      .fill_addr   (req_iaddr),
      .inv_en      ((state == S_DATA) && mem_ready && (req_wstrb != 4'h0)),
      .inv_addr    (req_daddr)
   );
`else
   assign fetch_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_COMMIT;
         imem_data  <= RESET_INSN;
         dmem_rdata <= '0;
         req_iaddr  <= '0;
         req_daddr  <= '0;
         req_wstrb  <= '0;
         req_wdata  <= '0;
      end else begin
         state <= state_next;
         if (state == S_COMMIT) begin
            req_iaddr <= imem_addr;
            req_daddr <= dmem_addr;
            req_wstrb <= dmem_wstrb;
            req_wdata <= dmem_wdata;
         end
         if ((state == S_DATA) && mem_ready && (req_wstrb == 4'h0))
            dmem_rdata <= mem_rdata;
         if ((state == S_FETCH) && mem_ready)
            imem_data <= mem_rdata;
      end
   end

   always_comb begin
      state_next = state;
      stall      = 1'b1;
      mem_valid  = 1'b0;
      mem_addr   = req_iaddr & MEMCTL_WORD_MASK;
      mem_wstrb  = '0;
      mem_wdata  = req_wdata;
      case (state)
         S_COMMIT: begin
            stall = 1'b0;
            if (dmem_valid)
               state_next = S_DATA;
            else if (fetch_hit)
               state_next = S_COMMIT;
            else
               state_next = S_FETCH;
         end
         S_DATA: begin
            mem_valid = 1'b1;
            mem_addr  = req_daddr & MEMCTL_WORD_MASK;
            mem_wstrb = req_wstrb;
            if (mem_ready)
               state_next = fetch_hit ? S_COMMIT : S_FETCH;
         end
         S_FETCH: begin
            mem_valid = 1'b1;
            if (mem_ready)
               state_next = S_COMMIT;
         end
         default: state_next = S_COMMIT;
      endcase
   end

endmodule

// File: tb/tb_stupidrv_memctl.sv
// Directed plus randomized bench for stupidrv_memctl against a step-level
// reference model and a wait-state-injecting bus memory.
module tb_stupidrv_memctl;

   localparam logic [31:0] RST_INSN = 32'h0000_0033;
   localparam logic [31:0] WMASK    = 32'hffff_fffc;
`ifdef STUPIDRV_MEMCTL_FETCHSKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } xact_t;

   logic        clock;
   logic        reset;
   logic        stall;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        dmem_valid;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   stupidrv_memctl #(.RESET_INSN(RST_INSN)) dut (
      .clock      (clock),
      .reset      (reset),
      .stall      (stall),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .dmem_valid (dmem_valid),
      .dmem_addr  (dmem_addr),
      .dmem_wstrb (dmem_wstrb),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9e37_79b1) + 32'h1;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // Bus-side memory (written by the DUT) and reference memory (written by the model)
   logic [31:0] bmem [int unsigned];
   logic [31:0] rmem [int unsigned];

   function automatic logic [31:0] bus_rd(input logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return rmem.exists(a) ? rmem[a] : init_word(a);
   endfunction

   xact_t       log_q[$];
   int unsigned wait_q[$];
   bit          busy = 1'b0;
   int unsigned cur_wait = 0;
   int unsigned wait_cnt = 0;
   logic [31:0] hold_addr, hold_wdata;
   logic [3:0]  hold_wstrb;

   // Bus responder: wait states per transaction from wait_q, noise on ready while idle
   always @(negedge clock) begin
      if (mem_valid === 1'b1) begin
         if (!busy) begin
            busy       = 1'b1;
            cur_wait   = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            wait_cnt   = 0;
            hold_addr  = mem_addr;
            hold_wstrb = mem_wstrb;
            hold_wdata = mem_wdata;
         end else begin
            chk("hold_addr", mem_addr, hold_addr);
            chk("hold_wstrb", {28'b0, mem_wstrb}, {28'b0, hold_wstrb});
            chk("hold_wdata", mem_wdata, hold_wdata);
         end
         if (wait_cnt == cur_wait) begin
            mem_ready = 1'b1;
            mem_rdata = bus_rd(mem_addr);
            log_q.push_back(xact_t'{mem_addr, mem_wstrb, mem_wdata});
            if (mem_wstrb != 4'h0)
               bmem[mem_addr] = merge(bus_rd(mem_addr), mem_wdata, mem_wstrb);
            busy = 1'b0;
         end else begin
            mem_ready = 1'b0;
            wait_cnt++;
         end
      end else begin
         busy      = 1'b0;
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
      end
   end

   // Reference model state: what the core should see at the next commit
   logic [31:0] m_imem, m_dmem, m_tag;
   bit          m_tag_valid;

   task automatic do_step(input bit dv, input logic [31:0] da, input logic [3:0] ws,
                          input logic [31:0] wd, input logic [31:0] ia,
                          input int unsigned wdw, input int unsigned wfw, input string tag);
      xact_t       exp_q[$];
      int unsigned exp_stall, n;
      bit          skip;
      log_q.delete();
      wait_q.delete();
      exp_stall = 0;
      if (dv) begin
         exp_q.push_back(xact_t'{da & WMASK, ws, wd});
         wait_q.push_back(wdw);
         exp_stall += 1 + wdw;
         if (ws != 4'h0) begin
            rmem[da & WMASK] = merge(ref_rd(da & WMASK), wd, ws);
            if (m_tag == (da & WMASK)) m_tag_valid = 1'b0;
         end else begin
            m_dmem = ref_rd(da & WMASK);
         end
      end
      skip = SKIP && m_tag_valid && (m_tag == (ia & WMASK));
      if (!skip) begin
         exp_q.push_back(xact_t'{ia & WMASK, 4'h0, 32'h0});
         wait_q.push_back(wfw);
         exp_stall += 1 + wfw;
         m_imem      = ref_rd(ia & WMASK);
         m_tag       = ia & WMASK;
         m_tag_valid = 1'b1;
      end
      dmem_valid = dv;
      dmem_addr  = da;
      dmem_wstrb = ws;
      dmem_wdata = wd;
      imem_addr  = ia;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (stall === 1'b1 && n < 64);
      chk({tag, "_commit_reached"}, {31'b0, stall}, 32'h0);
      chk({tag, "_stall_cycles"}, n - 1, exp_stall);
      chk({tag, "_bus_count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk({tag, "_bus_addr"}, log_q[i].addr, exp_q[i].addr);
         chk({tag, "_bus_wstrb"}, {28'b0, log_q[i].wstrb}, {28'b0, exp_q[i].wstrb});
         if (exp_q[i].wstrb != 4'h0)
            chk({tag, "_bus_wdata"}, log_q[i].wdata, exp_q[i].wdata);
      end
      chk({tag, "_imem_data"}, imem_data, m_imem);
      chk({tag, "_dmem_rdata"}, dmem_rdata, m_dmem);
   endtask

   initial begin
      reset      = 1'b1;
      dmem_valid = 1'b0;
      dmem_addr  = '0;
      dmem_wstrb = '0;
      dmem_wdata = '0;
      imem_addr  = 32'h0;
      bmem[0]    = 32'h0000_0013;
      rmem[0]    = 32'h0000_0013;
      m_tag_valid = 1'b0;
      m_tag      = '0;
      repeat (3) @(negedge clock);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
      chk("rst_imem_data", imem_data, RST_INSN);
      chk("rst_dmem_rdata", dmem_rdata, 32'h0);

      // Reset release: stall 0,1,0 and a single fetch at address 0
      log_q.delete();
      reset = 1'b0;
      chk("rel_stall_c0", {31'b0, stall}, 32'h0);
      @(negedge clock);
      chk("rel_stall_c1", {31'b0, stall}, 32'h1);
      @(negedge clock);
      chk("rel_stall_c2", {31'b0, stall}, 32'h0);
      chk("rel_imem_data", imem_data, 32'h0000_0013);
      chk("rel_bus_count", log_q.size(), 1);
      if (log_q.size() > 0) begin
         chk("rel_bus_addr", log_q[0].addr, 32'h0);
         chk("rel_bus_wstrb", {28'b0, log_q[0].wstrb}, 32'h0);
      end
      m_imem = 32'h0000_0013;
      m_dmem = 32'h0;
      m_tag = 32'h0;
      m_tag_valid = 1'b1;

      do_step(1'b1, 32'h100, 4'b0011, 32'h0000_beef, 32'h8, 0, 0, "store_fetch");
      do_step(1'b1, 32'h204, 4'h0, 32'h0, 32'hc, 3, 0, "wait_load");

      // Repeated fetch of one word, a store to it, then a load before a repeat
      do_step(1'b0, 32'h0, 4'h0, 32'h0, 32'h40, 0, 0, "f40_first");
      do_step(1'b0, 32'h0, 4'h0, 32'h0, 32'h40, 0, 0, "f40_repeat");
      do_step(1'b1, 32'h40, 4'hf, 32'h1234_5678, 32'h40, 0, 1, "f40_store");
      do_step(1'b1, 32'h204, 4'h0, 32'h0, 32'h40, 1, 0, "f40_load");

      // Reset while FETCH waits for mem_ready
      log_q.delete();
      wait_q.delete();
      wait_q.push_back(20);
      dmem_valid = 1'b0;
      imem_addr  = 32'h48;
      @(negedge clock);
      chk("mid_stall", {31'b0, stall}, 32'h1);
      chk("mid_mem_valid", {31'b0, mem_valid}, 32'h1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid_rst_mem_valid", {31'b0, mem_valid}, 32'h0);
      chk("mid_rst_stall", {31'b0, stall}, 32'h0);
      chk("mid_rst_imem_data", imem_data, RST_INSN);
      chk("mid_rst_dmem_rdata", dmem_rdata, 32'h0);
      chk("mid_rst_bus_count", log_q.size(), 0);
      m_imem = RST_INSN;
      m_dmem = 32'h0;
      m_tag_valid = 1'b0;

      for (int s = 0; s < 40; s++) begin
         logic [31:0] da, ia;
         logic [3:0]  ws;
         da = 32'h40 + 32'(4 * $urandom_range(0, 7));
         ia = 32'h40 + 32'(4 * $urandom_range(0, 7));
         ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         do_step(1'($urandom_range(0, 1)), da, ws, $urandom, ia,
                 $urandom_range(0, 2), $urandom_range(0, 2), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stupidrv_memctl.md
# stupidrv_memctl

Memory sequencer between the `stupidrv` core and one shared single-port 32-bit memory bus with a valid/ready handshake. The core's fixed-latency instruction port (`imem_*`) and data port (`dmem_*`) are serialised onto that bus. The block drives the core's `stall` input so that every step the core commits sees correct `imem_data` and `dmem_rdata`. It sits directly between the core and the SoC memory/interconnect.

## Interface
- `RESET_INSN`, default `32'h0000_0000`: value of `imem_data` after reset. It must decode as a non-load/non-store so that no data access is issued before the first fetch.
- `clock`  in  1  single clock, all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  out  1  to core; low only in the COMMIT state
- `imem_addr`  in  32  fetch address from the core
- `imem_data`  out  32  registered fetched word
- `dmem_valid`  in  1  data access request from the core
- `dmem_addr`  in  32  data address; the core has already aligned it
- `dmem_wstrb`  in  4  write byte strobes; `4'h0` means read
- `dmem_wdata`  in  32  write data
- `dmem_rdata`  out  32  registered read word
- `mem_valid`  out  1  bus request
- `mem_ready`  in  1  bus completion; read data is valid in the same cycle
- `mem_addr`  out  32  word address, bits [1:0] always 0
- `mem_wstrb`  out  4  0 for reads and for fetches
- `mem_wdata`  out  32  write data
- `mem_rdata`  in  32  bus read data

## Operation
- **States:** COMMIT, DATA, FETCH.
- **COMMIT** (`stall`=0):
  - The core consumes `imem_data`/`dmem_rdata` and presents its next requests.
  - At the clock edge the block captures `imem_addr`, `dmem_valid`, `dmem_addr`, `dmem_wstrb` and `dmem_wdata`.
  - Next state is DATA if `dmem_valid`=1, otherwise FETCH.
- **DATA** (`stall`=1):
  - `mem_valid`=1 with the captured data request.
  - When `mem_ready`=1: if the captured strobe is 0, `dmem_rdata` <= `mem_rdata`. Then go to FETCH.
- **FETCH** (`stall`=1):
  - `mem_valid`=1 with the captured `imem_addr` and `mem_wstrb`=0.
  - When `mem_ready`=1: `imem_data` <= `mem_rdata`, then go to COMMIT.
- **Data priority:** a data access always precedes the fetch of the same step. A store therefore becomes visible before the following fetch, so self-modifying code is coherent.
- Each captured request is issued on the bus exactly once, even though the core keeps presenting it while stalled.
- Bus requests are never issued from COMMIT.
- `dmem_rdata` keeps its old value across writes and fetches.
- **Reset:**
  - State <= COMMIT, `imem_data` <= `RESET_INSN`, `dmem_rdata` <= 0, `mem_valid`=0, `stall`=0.
  - Reset asserted in DATA or FETCH abandons the transfer; `mem_valid` drops in the next cycle, even if `mem_ready` is still outstanding.
  - The interconnect must tolerate an abandoned request.

## Timing
- `stall` and `mem_valid` are pure decodes of the state register; there is no combinational path from `mem_ready` to either.
- Bus rule: while `mem_valid`=1 and `mem_ready`=0, `mem_addr`, `mem_wstrb` and `mem_wdata` are held stable.
- `mem_ready` may be high in the first cycle of a request (zero wait states).
- Zero-wait commit-to-commit period: 2 cycles without a data access, 3 cycles with one. Each bus wait state adds 1 cycle.
- `imem_data`/`dmem_rdata` update on the edge that leaves FETCH/DATA and are stable throughout COMMIT.
- `mem_ready` while `mem_valid`=0 is ignored.

## Configuration
- **Macro:** `STUPIDRV_MEMCTL_FETCHSKIP_EN`.
- **Defined:**
  - A one-entry tag (valid bit plus word address) records the last completed fetch.
  - If the captured fetch word address equals the tag and the entry is valid, the FETCH bus cycle is skipped; the block goes to COMMIT directly and `imem_data` is unchanged.
  - A completed write whose word address matches the tag clears the valid bit. Reset clears it too.
  - Effect: the repeated fetch after a load costs 1 cycle less.
- **Undefined:** every step performs a FETCH bus cycle; there is no tag logic.

## Structure
- `stupidrv_pkg` holds the state enum (COMMIT/DATA/FETCH) and `MEMCTL_WORD_MASK = 32'hffff_fffc`.
- One sub-module, `stupidrv_memctl_fetchtag`, holds the skip tag (lookup, fill, invalidate). It is instantiated only under `STUPIDRV_MEMCTL_FETCHSKIP_EN`.

## Test plan
- **Reset release:** release reset with `imem_addr=0x0` and zero-wait memory holding `0x00000013` at 0 -> `stall` reads 0,1,0 over the first three cycles, exactly one bus read at address 0, `imem_data=0x00000013` in the second COMMIT.
- **Store then fetch:** store with `dmem_addr=0x100`, `wstrb=4'b0011`, `wdata=0x0000BEEF`, plus `imem_addr=0x8` -> bus write to `0x100` with strobe `0011`, then a read at `0x8`, in that order. One write only, despite 2 stalled cycles.
- **Wait states:** load at `0x204` with `mem_ready` delayed 3 cycles -> address, strobe and data on the bus are stable for 4 cycles. `dmem_rdata` equals the memory word at `0x204` in the next COMMIT, and `stall` is high for 3+1+1 cycles.
- **Reset mid-transfer:** reset asserted in FETCH while `mem_ready`=0 -> `mem_valid`=0 in the next cycle, state COMMIT, `imem_data=RESET_INSN`.
- **Fetch skip (macro defined):** same `imem_addr=0x40` twice -> the second step issues no bus read. After an intervening write to `0x40`, the next fetch of `0x40` reads the bus again.
- **Fetch skip (macro undefined):** same `imem_addr=0x40` twice -> both steps read the bus.
